// File: rtl/key_event_queue_if.sv
// CPU-facing bundle of the key event queue: debounced key levels in, head event,
// fill level and sticky overflow out.
interface key_event_queue_if #(
   parameter int NKEYS = 8,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NKEYS-1:0] keys;
   logic             rd;
   logic             clr;
   logic [7:0]       ev_data;
   logic             ev_valid;
   logic [CW-1:0]    count;
   logic             overflow;

   modport master (
      output keys, rd, clr,
      input  ev_data, ev_valid, count, overflow
   );

   modport slave (
      input  keys, rd, clr,
      output ev_data, ev_valid, count, overflow
   );
endinterface

// File: rtl/key_event_queue.sv
// Turns debounced key levels into press/release/auto-repeat events held in a
// first-word-fall-through FIFO that the CPU pops one entry at a time.
module key_event_queue #(
   parameter int          NKEYS        = 8,
   parameter int          DEPTH        = 8,
   parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
   parameter logic [23:0] REPEAT_RATE  = 24'd1000000
) (
   input logic              clk,
   input logic              rst,
   key_event_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   logic [NKEYS-1:0] prev_q, prev_d;
   logic [NKEYS-1:0] pend_p_q, pend_p_d;
   logic [NKEYS-1:0] pend_r_q, pend_r_d;
   logic             rep_active_q, rep_active_d;
   logic             rep_pend_q, rep_pend_d;
   logic [5:0]       rep_key_q, rep_key_d;
   logic [23:0]      rep_cnt_q, rep_cnt_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       mem_q [DEPTH];

   logic [NKEYS-1:0] rise_s, fall_s;
   logic [63:0]      keys_ext_s, pend_p_ext_s;
   logic [63:0]      svc_p_s, svc_r_s;
   logic             svc_rep_s;
   logic             found_s;
   logic [5:0]       idx_s;
   logic             ev_req_s;
   logic [7:0]       ev_s;
   logic [PW-1:0]    count_s;
   logic             full_s, empty_s, pop_s, push_s, push_en_s;

   // Lowest set index; the downward scan leaves the smallest match in r.
   function automatic logic [6:0] find_first(input logic [NKEYS-1:0] v);
      logic [6:0] r;
      r = 7'd0;
      for (int k = NKEYS - 1; k >= 0; k--) begin
         if (v[k]) r = {1'b1, 6'(k)};
      end
      return r;
   endfunction

   assign keys_ext_s   = 64'(bus.keys);
   assign pend_p_ext_s = 64'(pend_p_q);
   assign rise_s       = bus.keys & ~prev_q;
   assign fall_s       = ~bus.keys & prev_q;
   assign count_s      = wr_ptr_q - rd_ptr_q;
   assign full_s       = (count_s == PW'(DEPTH));
   assign empty_s      = (count_s == PW'(0));
   assign pop_s        = bus.rd && !empty_s;
   assign push_s       = ev_req_s && (!full_s || pop_s);
   assign push_en_s    = push_s && !bus.clr;

   // Arbiter: one event per cycle, pending edges by index, then the repeat.
   always_comb begin
      {found_s, idx_s} = find_first(pend_p_q | pend_r_q);
      svc_p_s   = 64'd0;
      svc_r_s   = 64'd0;
      svc_rep_s = 1'b0;
      ev_req_s  = 1'b0;
      ev_s      = 8'h00;
      if (found_s) begin
         ev_req_s = 1'b1;
         if (pend_p_ext_s[idx_s]) begin
            ev_s    = {EV_PRESS, idx_s};
            svc_p_s = 64'd1 << idx_s;
         end else begin
            ev_s    = {EV_RELEASE, idx_s};
            svc_r_s = 64'd1 << idx_s;
         end
      end else if (rep_pend_q) begin
         ev_req_s  = 1'b1;
         ev_s      = {EV_REPEAT, rep_key_q};
         svc_rep_s = 1'b1;
      end else begin
         ev_req_s = 1'b0;
      end
   end

   // Next state of edge flags, repeat tracker, pointers and overflow.
   always_comb begin
      prev_d       = bus.keys;
      pend_p_d     = '0;
      pend_r_d     = '0;
      rep_active_d = 1'b0;
      rep_pend_d   = 1'b0;
      rep_key_d    = rep_key_q;
      rep_cnt_d    = rep_cnt_q;
      wr_ptr_d     = PW'(0);
      rd_ptr_d     = PW'(0);
      overflow_d   = 1'b0;
      if (bus.clr) begin
         rep_key_d = 6'd0;
         rep_cnt_d = 24'd0;
      end else begin
         pend_p_d     = (pend_p_q & ~svc_p_s[NKEYS-1:0]) | rise_s;
         pend_r_d     = (pend_r_q & ~svc_r_s[NKEYS-1:0]) | fall_s;
         wr_ptr_d     = wr_ptr_q + PW'(push_s);
         rd_ptr_d     = rd_ptr_q + PW'(pop_s);
         overflow_d   = overflow_q || (ev_req_s && !push_s);
         rep_active_d = rep_active_q;
         rep_pend_d   = rep_pend_q && !svc_rep_s;
         if (push_s && (ev_s[7:6] == EV_PRESS)) begin
            rep_key_d    = ev_s[5:0];
            rep_active_d = 1'b1;
            rep_pend_d   = 1'b0;
            rep_cnt_d    = REPEAT_DELAY;
         end else if (rep_active_q) begin
            if (!keys_ext_s[rep_key_q]) begin
               rep_active_d = 1'b0;
               rep_pend_d   = 1'b0;
            end else if (rep_cnt_q == 24'd1) begin
               rep_pend_d = 1'b1;
               rep_cnt_d  = REPEAT_RATE;
            end else begin
               rep_cnt_d = rep_cnt_q - 24'd1;
            end
         end else begin
            rep_cnt_d = rep_cnt_q;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q       <= '0;
         pend_p_q     <= '0;
         pend_r_q     <= '0;
         rep_active_q <= 1'b0;
         rep_pend_q   <= 1'b0;
         rep_key_q    <= 6'd0;
         rep_cnt_q    <= 24'd0;
         wr_ptr_q     <= PW'(0);
         rd_ptr_q     <= PW'(0);
         overflow_q   <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         pend_p_q     <= pend_p_d;
         pend_r_q     <= pend_r_d;
         rep_active_q <= rep_active_d;
         rep_pend_q   <= rep_pend_d;
         rep_key_q    <= rep_key_d;
         rep_cnt_q    <= rep_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
      end
   end

   // FIFO storage; contents are only visible while non-empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_en_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= ev_s;
      end
   end

   assign bus.ev_valid = !empty_s;
   assign bus.count    = count_s;
   assign bus.overflow = overflow_q;
   assign bus.ev_data  = empty_s ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_key_event_queue;
   localparam int NK = 8;
   localparam int DP = 4;
   localparam int RD = 10;
   localparam int RR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   key_event_queue_if #(.NKEYS(NK), .DEPTH(DP)) bus ();

   key_event_queue #(
      .NKEYS(NK), .DEPTH(DP),
      .REPEAT_DELAY(24'd10), .REPEAT_RATE(24'd4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- reference model (event-level, queue based) ----------------
   bit          m_prev [NK];
   bit          m_pp [NK];
   bit          m_pr [NK];
   bit          m_ra, m_rp, m_ovf;
   int          m_rk;
   longint      m_due, m_cyc;
   logic [7:0]  m_q [$];

   task automatic model_reset();
      for (int i = 0; i < NK; i++) begin
         m_prev[i] = 1'b0; m_pp[i] = 1'b0; m_pr[i] = 1'b0;
      end
      m_ra = 1'b0; m_rp = 1'b0; m_ovf = 1'b0; m_rk = 0; m_due = 0; m_cyc = 0;
      m_q.delete();
   endtask

   task automatic model_step(input logic [7:0] k, input bit r, input bit c);
      int         sel;
      bit         has, pushed;
      logic [7:0] ev;
      sel = -1; has = 1'b0; pushed = 1'b0; ev = 8'h00;
      for (int i = 0; i < NK; i++) if (sel < 0 && (m_pp[i] || m_pr[i])) sel = i;
      if (sel >= 0) begin
         has = 1'b1;
         ev  = m_pp[sel] ? (8'h40 | 8'(sel)) : (8'h80 | 8'(sel));
      end else if (m_rp) begin
         has = 1'b1;
         ev  = 8'hC0 | 8'(m_rk);
      end
      if (c) begin
         m_q.delete();
         for (int i = 0; i < NK; i++) begin m_pp[i] = 1'b0; m_pr[i] = 1'b0; end
         m_ra = 1'b0; m_rp = 1'b0; m_ovf = 1'b0;
      end else begin
         if (r && m_q.size() > 0) void'(m_q.pop_front());
         if (has) begin
            if (m_q.size() < DP) begin m_q.push_back(ev); pushed = 1'b1; end
            else m_ovf = 1'b1;
         end
         if (sel >= 0) begin
            if (m_pp[sel]) m_pp[sel] = 1'b0; else m_pr[sel] = 1'b0;
         end else if (has) begin
            m_rp = 1'b0;
         end
         for (int i = 0; i < NK; i++) begin
            if (k[i] && !m_prev[i]) m_pp[i] = 1'b1;
            if (!k[i] && m_prev[i]) m_pr[i] = 1'b1;
         end
         if (pushed && ev[7:6] == 2'b01) begin
            m_rk = int'(ev[5:0]); m_ra = 1'b1; m_rp = 1'b0; m_due = m_cyc + RD;
         end else if (m_ra) begin
            if (!k[m_rk]) begin
               m_ra = 1'b0; m_rp = 1'b0;
            end else if (m_cyc == m_due) begin
               m_rp = 1'b1; m_due = m_cyc + RR;
            end
         end
      end
      for (int i = 0; i < NK; i++) m_prev[i] = k[i];
      m_cyc++;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs for one rising edge, advance the model, sample 1 time unit later.
   task automatic step(input logic [7:0] k, input bit r, input bit c);
      bus.keys = k; bus.rd = r; bus.clr = c;
      @(posedge clk);
      model_step(k, r, c);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_valid"}, 32'(bus.ev_valid), 32'(m_q.size() > 0));
      chk({tag, "_count"}, 32'(bus.count), 32'(m_q.size()));
      chk({tag, "_data"}, 32'(bus.ev_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
   endtask

   typedef struct {
      logic [7:0] keys;
      logic       rd;
      logic       clr;
      logic [7:0] data;
      logic       valid;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl [23];

   task automatic setv(input int i, input logic [7:0] k, input logic r, input logic c,
                       input logic [7:0] d, input logic v, input logic [2:0] n);
      tbl[i] = '{keys: k, rd: r, clr: c, data: d, valid: v, cnt: n};
   endtask

   typedef struct { int edge_n; logic [7:0] data; } log_t;
   log_t ev_log [$];
   int   exp_edge [7];
   logic [7:0] exp_dat [7];

   initial begin
      logic [7:0] rk;
      bus.keys = 8'h00; bus.rd = 1'b0; bus.clr = 1'b0;
      model_reset();

      // single key, simultaneous edges, empty pop, full without overflow
      setv(0, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
      for (int i = 1; i <= 10; i++) setv(i, (i <= 9) ? 8'h04 : 8'h00, 1'b0, 1'b0, 8'h42, 1'b1, 3'd1);
      setv(11, 8'h00, 1'b0, 1'b0, 8'h42, 1'b1, 3'd2);
      setv(12, 8'h00, 1'b1, 1'b0, 8'h82, 1'b1, 3'd1);
      setv(13, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
      setv(14, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
      setv(15, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0);
      setv(16, 8'h81, 1'b0, 1'b0, 8'h40, 1'b1, 3'd1);
      setv(17, 8'h81, 1'b0, 1'b0, 8'h40, 1'b1, 3'd2);
      setv(18, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 3'd2);
      setv(19, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 3'd3);
      setv(20, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 3'd4);
      setv(21, 8'h00, 1'b1, 1'b0, 8'h47, 1'b1, 3'd3);
      setv(22, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0);

      #12;
      chk("reset_valid", 32'(bus.ev_valid), 32'h0);
      chk("reset_count", 32'(bus.count), 32'h0);
      chk("reset_data", 32'(bus.ev_data), 32'h0);
      chk("reset_ovf", 32'(bus.overflow), 32'h0);
      @(posedge clk); #1; rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].keys, tbl[i].rd, tbl[i].clr);
         chk($sformatf("tbl%0d_data", i), 32'(bus.ev_data), 32'(tbl[i].data));
         chk($sformatf("tbl%0d_valid", i), 32'(bus.ev_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'h0);
      end

      // auto-repeat: hold key 3 for 30 edges, popping continuously
      exp_edge = '{2, 13, 17, 21, 25, 29, 32};
      exp_dat  = '{8'h43, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h83};
      for (int i = 1; i <= 45; i++) begin
         step((i <= 30) ? 8'h08 : 8'h00, 1'b1, 1'b0);
         if (bus.ev_valid) ev_log.push_back('{edge_n: i, data: bus.ev_data});
      end
      chk("rep_nevents", 32'(ev_log.size()), 32'd7);
      for (int j = 0; j < 7; j++) begin
         if (j < ev_log.size()) begin
            chk($sformatf("rep%0d_edge", j), 32'(ev_log[j].edge_n), 32'(exp_edge[j]));
            chk($sformatf("rep%0d_data", j), 32'(ev_log[j].data), 32'(exp_dat[j]));
         end else begin
            chk($sformatf("rep%0d_missing", j), 32'h0, 32'h1);
         end
      end

      // overflow with DEPTH=4
      step(8'h00, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) step(8'h1F, 1'b0, 1'b0);
      chk("ovf_pre_count", 32'(bus.count), 32'd4);
      chk("ovf_pre_flag", 32'(bus.overflow), 32'd0);
      step(8'h1F, 1'b0, 1'b0);
      chk("ovf_count", 32'(bus.count), 32'd4);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_head", 32'(bus.ev_data), 32'h40);
      step(8'h1E, 1'b0, 1'b0);
      chk("ovf_hold_count", 32'(bus.count), 32'd4);
      step(8'h1E, 1'b1, 1'b0);
      chk("ovf_rdpush_count", 32'(bus.count), 32'd4);
      chk("ovf_rdpush_head", 32'(bus.ev_data), 32'h41);
      chk("ovf_rdpush_flag", 32'(bus.overflow), 32'd1);
      step(8'h1E, 1'b0, 1'b1);
      chk("clr_count", 32'(bus.count), 32'd0);
      chk("clr_flag", 32'(bus.overflow), 32'd0);
      step(8'h1E, 1'b0, 1'b0);
      step(8'h1E, 1'b0, 1'b0);
      chk("clr_held_nopress", 32'(bus.count), 32'd0);
      step(8'h00, 1'b0, 1'b1);

      // reset mid-stream with 3 entries queued and a repeat armed
      for (int i = 1; i <= 5; i++) step(8'h07, 1'b0, 1'b0);
      chk("mid_pre_count", 32'(bus.count), 32'd3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_valid", 32'(bus.ev_valid), 32'h0);
      chk("mid_rst_count", 32'(bus.count), 32'h0);
      chk("mid_rst_data", 32'(bus.ev_data), 32'h0);
      bus.keys = 8'h02;
      @(posedge clk); #1; rst = 1'b0;
      step(8'h02, 1'b0, 1'b0);
      chk("mid_e1_count", 32'(bus.count), 32'd0);
      for (int i = 2; i <= 8; i++) step(8'h02, 1'b0, 1'b0);
      chk("mid_count", 32'(bus.count), 32'd1);
      chk("mid_head", 32'(bus.ev_data), 32'h41);

      // randomized run against the model
      rk = 8'h02;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) rk = rk ^ (8'h01 << $urandom_range(0, 7));
         step(rk, ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Converts the debounced key levels produced by the key debouncers into a queue of discrete press, release and auto-repeat events for the CPU to pop. It sits directly downstream of the per-key debouncers, one level bit per key, and upstream of the IO register block. The CPU reads the head event, pops it, and can check the fill level and a sticky overflow flag.

## Interface
- NKEYS, 8: number of debounced key inputs, 1..64.
- DEPTH, 8: FIFO entries, power of two, 2..64.
- REPEAT_DELAY, 24'd5000000: cycles a key is held before its first repeat event, ≥1.
- REPEAT_RATE, 24'd1000000: cycles between subsequent repeat events, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- keys  in  NKEYS  debounced key levels, 1 = held; synchronous to clk.
- rd  in  1  pop the head event; ignored when empty.
- clr  in  1  synchronous: flush the FIFO, all pending flags, repeat state and overflow.
- ev_data  out  8  head event: [7:6] type (01 press, 10 release, 11 repeat), [5:0] key index. 8'h00 when empty.
- ev_valid  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  entries in the FIFO.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Edge detect: the prev register is NKEYS wide. A rise on key k (keys & ~prev) sets pend_p[k]; a fall sets pend_r[k]. An edge on an already-set flag coalesces; no overflow is flagged.
- Arbiter: at most one event is generated per cycle. Priority:
  - lowest key index with any pending edge; for that key, press before release;
  - then the repeat-pending flag.
- The serviced flag clears in the same cycle the event is pushed, or dropped on full.
- Repeat tracker: rep_active, rep_key (6 bits) and a 24-bit down-counter.
  - Pushing a press event for key k: rep_key←k, rep_active←1, counter←REPEAT_DELAY, rep_pend←0.
  - While rep_active and keys[rep_key]=1, the counter decrements each cycle. When it reaches 1, rep_pend←1 and counter←REPEAT_RATE.
  - When keys[rep_key]=0: rep_active←0 and rep_pend←0; no repeat is emitted after release.
  - A later press of another key takes over the repeat tracker.
- FIFO:
  - First-word-fall-through; read/write pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full when count==DEPTH.
  - Push while full: the event is dropped and overflow←1. Exception: a push and a valid rd in the same cycle when full are both accepted, and count is unchanged.
  - Push and rd when empty: the push is accepted and rd is ignored.
- clr has priority over push, pop and edge capture in its cycle. prev is still updated to keys, so held keys do not re-generate press events.
- Reset values:
  - prev, all pending flags, rep state and pointers = 0;
  - ev_valid=0, count=0, overflow=0, ev_data=8'h00.
- A key already high when reset is released produces a press event.

## Timing
- keys[k] rises before clock edge t: pend_p[k] is set at edge t; the event is written at edge t+1; ev_valid=1 after edge t+1. Latency is 2 cycles when uncontended.
- N simultaneous edges take N consecutive cycles to drain, in index order.
- rd at edge t: count decrements, and ev_data/ev_valid show the next entry after edge t.
- First repeat: REPEAT_DELAY+1 cycles after the press push. Subsequent repeats: every REPEAT_RATE cycles, plus any cycles lost to arbitration against edge events.
- Reset asserted mid-operation clears all state immediately and asynchronously; outputs take reset values without waiting for clk.

## Test plan
- Single key: keys=8'h04 for 10 cycles, then 8'h00 → two entries, 8'h42 then 8'h82. ev_valid rises 2 cycles after the rising stimulus; count=2.
- Simultaneous edges: keys 0→8'h81 → events 8'h40 then 8'h47 on consecutive cycles; count=2.
- Auto-repeat with REPEAT_DELAY=10, REPEAT_RATE=4: hold key 3 for 30 cycles →
  - press 8'h43;
  - first 8'hC3 11 cycles after the press push, then 8'hC3 every 4 cycles;
  - release 8'h83 last;
  - no repeat after release.
- Overflow with DEPTH=4: 5 events generated with no rd → count=4, overflow=1, the 5th event is absent. Then rd at full with a simultaneous push → count stays 4. Then clr → count=0, overflow=0.
- Empty pop: rd while empty → count stays 0, ev_data=8'h00; no pointer corruption on the next push/pop.
- Reset mid-stream: assert rst with 3 entries queued and a repeat armed → ev_valid=0 and count=0 immediately. After release with key 1 held → a single 8'h41 event.
